// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl
// Brief    : Forwarding, load-use stall, flush and memory-freeze control
//            for the 5-stage RV32I pipeline, with stall counters.
// Revision : 1.0
// ============================================================================
module hazard_ctrl #(
    parameter int TIMEOUT   = 256,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [4:0]           Rs1D,
    input  logic [4:0]           Rs2D,
    input  logic [4:0]           Rs1E,
    input  logic [4:0]           Rs2E,
    input  logic [4:0]           RdE,
    input  logic                 RegWriteE,
    input  logic [1:0]           ResultSrcE,
    input  logic                 PCSrcE,
    input  logic                 mem_req_valid,
    input  logic                 mem_ready,
    output logic                 StallF,
    output logic                 StallD,
    output logic                 StallEMW,
    output logic                 FlushD,
    output logic                 FlushE,
    output logic [1:0]           ForwardAE,
    output logic [1:0]           ForwardBE,
    output logic                 mem_error,
    output logic [CNT_WIDTH-1:0] lw_stall_cnt,
    output logic [CNT_WIDTH-1:0] mem_stall_cnt
);

    localparam int WCW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        S_RUN  = 2'd0,
        S_WAIT = 2'd1,
        S_ERR  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [WCW-1:0]       wait_cnt_q, wait_cnt_d;
    logic [4:0]           rd_m_q, rd_m_d, rd_w_q, rd_w_d;
    logic                 reg_write_m_q, reg_write_m_d;
    logic                 reg_write_w_q, reg_write_w_d;
    logic [CNT_WIDTH-1:0] lw_cnt_q, lw_cnt_d, mem_cnt_q, mem_cnt_d;

    logic mem_stall, lw_stall, halted;

    always_comb begin
        ForwardAE = 2'b00;
        if (reg_write_m_q && (rd_m_q != 5'd0) && (rd_m_q == Rs1E))
            ForwardAE = 2'b10;
        else if (reg_write_w_q && (rd_w_q != 5'd0) && (rd_w_q == Rs1E))
            ForwardAE = 2'b01;

        ForwardBE = 2'b00;
        if (reg_write_m_q && (rd_m_q != 5'd0) && (rd_m_q == Rs2E))
            ForwardBE = 2'b10;
        else if (reg_write_w_q && (rd_w_q != 5'd0) && (rd_w_q == Rs2E))
            ForwardBE = 2'b01;
    end

    assign lw_stall = (ResultSrcE == 2'b01) && (RdE != 5'd0) &&
                      ((RdE == Rs1D) || (RdE == Rs2D));

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        mem_stall  = 1'b0;
        halted     = 1'b0;
        unique case (state_q)
            S_RUN: begin
                mem_stall = mem_req_valid & ~mem_ready;
                if (mem_stall) begin
                    state_d    = S_WAIT;
                    wait_cnt_d = WCW'(1);
                end
            end
            S_WAIT: begin
                mem_stall = ~mem_ready;
                if (mem_ready)
                    state_d = S_RUN;
                else if (wait_cnt_q == WCW'(TIMEOUT - 1))
                    state_d = S_ERR;
                else
                    wait_cnt_d = wait_cnt_q + WCW'(1);
            end
            default: halted = 1'b1;
        endcase
    end

    always_comb begin
        StallF   = lw_stall;
        StallD   = lw_stall;
        StallEMW = 1'b0;
        FlushD   = PCSrcE;
        FlushE   = lw_stall | PCSrcE;
        if (halted) begin
            StallF   = 1'b1;
            StallD   = 1'b1;
            StallEMW = 1'b1;
            FlushD   = 1'b0;
            FlushE   = 1'b1;
        end else if (mem_stall) begin
            StallF   = 1'b1;
            StallD   = 1'b1;
            StallEMW = 1'b1;
            FlushD   = 1'b0;
            FlushE   = 1'b0;
        end
    end

    // Shadows advance only when the pipe moves; counters saturate at all-ones.
    always_comb begin
        rd_m_d        = rd_m_q;
        rd_w_d        = rd_w_q;
        reg_write_m_d = reg_write_m_q;
        reg_write_w_d = reg_write_w_q;
        lw_cnt_d      = lw_cnt_q;
        mem_cnt_d     = mem_cnt_q;
        if (!mem_stall && !halted) begin
            rd_m_d        = RdE;
            reg_write_m_d = RegWriteE;
            rd_w_d        = rd_m_q;
            reg_write_w_d = reg_write_m_q;
            if (lw_stall && (lw_cnt_q != '1))
                lw_cnt_d = lw_cnt_q + CNT_WIDTH'(1);
        end
        if (mem_stall && (mem_cnt_q != '1))
            mem_cnt_d = mem_cnt_q + CNT_WIDTH'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_RUN;
            wait_cnt_q    <= '0;
            rd_m_q        <= '0;
            rd_w_q        <= '0;
            reg_write_m_q <= 1'b0;
            reg_write_w_q <= 1'b0;
            lw_cnt_q      <= '0;
            mem_cnt_q     <= '0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            rd_m_q        <= rd_m_d;
            rd_w_q        <= rd_w_d;
            reg_write_m_q <= reg_write_m_d;
            reg_write_w_q <= reg_write_w_d;
            lw_cnt_q      <= lw_cnt_d;
            mem_cnt_q     <= mem_cnt_d;
        end
    end

    assign mem_error     = (state_q == S_ERR);
    assign lw_stall_cnt  = lw_cnt_q;
    assign mem_stall_cnt = mem_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// Directed bench for hazard_ctrl: dut_a uses TIMEOUT=4, dut_b uses a 4-bit counter.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] Rs1D = '0, Rs2D = '0, Rs1E = '0, Rs2E = '0, RdE = '0;
    logic       RegWriteE = 1'b0, PCSrcE = 1'b0;
    logic [1:0] ResultSrcE = '0;
    logic       mem_req_valid = 1'b0, mem_ready = 1'b0;

    logic        a_sf, a_sd, a_semw, a_fd, a_fe, a_err;
    logic [1:0]  a_fa, a_fb;
    logic [15:0] a_lw, a_ms;
    logic        b_sf, b_sd, b_semw, b_fd, b_fe, b_err;
    logic [1:0]  b_fa, b_fb;
    logic [3:0]  b_lw, b_ms;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.TIMEOUT(4), .CNT_WIDTH(16)) dut_a (
        .clk(clk), .rst(rst), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE),
        .mem_req_valid(mem_req_valid), .mem_ready(mem_ready),
        .StallF(a_sf), .StallD(a_sd), .StallEMW(a_semw), .FlushD(a_fd), .FlushE(a_fe),
        .ForwardAE(a_fa), .ForwardBE(a_fb), .mem_error(a_err),
        .lw_stall_cnt(a_lw), .mem_stall_cnt(a_ms));

    hazard_ctrl #(.TIMEOUT(256), .CNT_WIDTH(4)) dut_b (
        .clk(clk), .rst(rst), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE),
        .mem_req_valid(mem_req_valid), .mem_ready(mem_ready),
        .StallF(b_sf), .StallD(b_sd), .StallEMW(b_semw), .FlushD(b_fd), .FlushE(b_fe),
        .ForwardAE(b_fa), .ForwardBE(b_fb), .mem_error(b_err),
        .lw_stall_cnt(b_lw), .mem_stall_cnt(b_ms));

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Packs {StallF,StallD,StallEMW,FlushD,FlushE} for dut_a.
    function automatic logic [15:0] ctl_a();
        return {11'd0, a_sf, a_sd, a_semw, a_fd, a_fe};
    endfunction

    initial begin
        #2;
        chk("reset_ctl", ctl_a(), 16'h0);
        chk("reset_fwd", {12'd0, a_fa, a_fb}, 16'h0);
        chk("reset_err", {15'd0, a_err}, 16'h0);
        chk("reset_cnt", a_lw | a_ms, 16'h0);
        tick();
        rst = 1'b0;
        tick();

        // Forwarding: x5 retired twice, then x6 younger, then x0
        RegWriteE = 1'b1; RdE = 5'd5;
        tick(); tick();
        Rs1E = 5'd5; #1;
        chk("fwdA_M_over_W", {14'd0, a_fa}, 16'h2);
        RdE = 5'd6; tick();
        Rs2E = 5'd6; #1;
        chk("fwdA_W", {14'd0, a_fa}, 16'h1);
        chk("fwdB_M", {14'd0, a_fb}, 16'h2);
        RdE = 5'd0; tick();
        chk("fwdA_none", {14'd0, a_fa}, 16'h0);
        chk("fwdB_W", {14'd0, a_fb}, 16'h1);
        tick();
        Rs2E = 5'd0; #1;
        chk("fwdB_x0", {14'd0, a_fb}, 16'h0);

        // Load-use
        RegWriteE = 1'b1; ResultSrcE = 2'b01; RdE = 5'd7; Rs2D = 5'd7; #1;
        chk("lw_ctl", ctl_a(), 16'b11001);
        tick();
        chk("lw_cnt1", a_lw, 16'd1);
        Rs1D = 5'd8; Rs2D = 5'd8; #1;
        chk("lw_nomatch", ctl_a(), 16'h0);

        // Branch plus load-use
        Rs2D = 5'd7; PCSrcE = 1'b1; #1;
        chk("br_lw_ctl", ctl_a(), 16'b11011);
        tick();
        chk("lw_cnt2", a_lw, 16'd2);
        PCSrcE = 1'b0; ResultSrcE = 2'b00; #1;
        chk("br_only_off", ctl_a(), 16'h0);

        // Memory wait of three cycles; shadows must hold x3
        RdE = 5'd3; RegWriteE = 1'b1;
        tick(); tick();
        RdE = 5'd9; Rs1E = 5'd3; #1;
        chk("pre_mem_fwd", {14'd0, a_fa}, 16'h2);
        mem_req_valid = 1'b1; mem_ready = 1'b0;
        ResultSrcE = 2'b01; RdE = 5'd7; PCSrcE = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("memwait_ctl", ctl_a(), 16'b11100);
            tick();
        end
        ResultSrcE = 2'b00; RdE = 5'd9; PCSrcE = 1'b0; mem_ready = 1'b1; #1;
        chk("mem_release_ctl", ctl_a(), 16'h0);
        chk("mem_hold_fwd", {14'd0, a_fa}, 16'h2);
        chk("mem_cnt3", a_ms, 16'd3);
        chk("lw_masked", a_lw, 16'd2);
        tick();
        chk("run_same_cycle_ready", ctl_a(), 16'h0);
        chk("mem_cnt_still3", a_ms, 16'd3);
        chk("no_err", {15'd0, a_err}, 16'h0);
        tick();
        chk("mem_cnt_final3", a_ms, 16'd3);

        // Saturation on dut_b: 20 memory-stall cycles
        mem_ready = 1'b0; mem_req_valid = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        chk("sat_cnt", {12'd0, b_ms}, 16'd15);
        chk("sat_no_err", {15'd0, b_err}, 16'h0);
        mem_req_valid = 1'b0; mem_ready = 1'b1; RegWriteE = 1'b0;
        RdE = '0; Rs1E = '0; Rs1D = '0; Rs2D = '0;
        #1 rst = 1'b1;
        #1;
        chk("async_rst_cnt", {12'd0, b_ms}, 16'd0);
        chk("async_rst_a_ctl", ctl_a(), 16'h0);
        tick();
        rst = 1'b0;
        tick();

        // Timeout on dut_a: exactly four stalled cycles then ERR
        mem_req_valid = 1'b1; mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("to_stall_ctl", ctl_a(), 16'b11100);
            chk("to_no_err", {15'd0, a_err}, 16'h0);
            tick();
        end
        chk("to_err", {15'd0, a_err}, 16'h1);
        chk("to_halt_ctl", ctl_a(), 16'b11101);
        mem_ready = 1'b1; PCSrcE = 1'b1;
        tick(); tick();
        chk("err_sticky", {15'd0, a_err}, 16'h1);
        chk("err_halt_ctl", ctl_a(), 16'b11101);
        chk("err_cnt_frozen", a_ms, 16'd4);

        // Async reset mid-ERR with inputs low
        mem_req_valid = 1'b0; mem_ready = 1'b0; PCSrcE = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("rst_err_ctl", ctl_a(), 16'h0);
        chk("rst_err_flag", {15'd0, a_err}, 16'h0);
        chk("rst_err_cnt", a_lw | a_ms, 16'h0);
        chk("rst_err_fwd", {12'd0, a_fa, a_fb}, 16'h0);
        tick();
        rst = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
